// File: rtl/aes_key_sequencer_pkg.sv
// Shared definitions for the AES-128 key sequencer: key and epoch widths,
// FSM state encoding, and a helper for sizing the shared cycle counter.
package aes_key_sequencer_pkg;

  localparam int AES_KEY_WIDTH = 128;
  localparam int EPOCH_WIDTH   = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRAIN = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RUN   = 3'd4
  } seq_state_t;

  // Largest of the three phase lengths; the counter must hold it.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return m;
  endfunction

endpackage

// File: rtl/aes_cycle_counter.sv
// Loadable down-counter shared by the DRAIN/START/WAIT phases.
//   clock, resetN : clock and asynchronous active-low reset
//   load, load_val: load a new count (has priority over dec)
//   dec           : decrement by one, saturating at zero
//   zero          : count is zero
module aes_cycle_counter #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         resetN,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN)                count <= '0;
    else if (load)              count <= load_val;
    else if (dec && count != '0) count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/aes_key_sequencer.sv
// Sequencer for the pipelined AES-128 key_creation block.
// Accepts a cipher key over valid/ready, drains the encrypt pipeline if it
// was running, pulses startTransition, waits for round keys to settle, then
// re-opens the datapath and bumps keyEpoch.
//   clock, resetN    : clock, asynchronous active-low reset
//   keyIn, keyValid  : key source; held until keyAccept
//   keyAccept        : sequencer takes a key this cycle (IDLE or RUN)
//   roundKeyInput    : registered key to key_creation
//   startTransition  : registered start pulse to key_creation
//   dataValidIn      : upstream block strobe (legal only when !dataStall)
//   dataStall        : upstream must not issue blocks
//   keysReady        : round keys valid for the current key
//   keyEpoch         : count of completed key loads (wraps)
module aes_key_sequencer
  import aes_key_sequencer_pkg::*;
#(
  parameter int START_PULSE_CYCLES = 5,
  parameter int KEY_LATENCY        = 11,
  parameter int PIPE_DEPTH         = 11
) (
  input  logic                     clock,
  input  logic                     resetN,
  input  logic [AES_KEY_WIDTH-1:0] keyIn,
  input  logic                     keyValid,
  output logic                     keyAccept,
  output logic [AES_KEY_WIDTH-1:0] roundKeyInput,
  output logic                     startTransition,
  input  logic                     dataValidIn,
  output logic                     dataStall,
  output logic                     keysReady,
  output logic [EPOCH_WIDTH-1:0]   keyEpoch
);

  localparam int CNT_W = $clog2(max3(START_PULSE_CYCLES, KEY_LATENCY, PIPE_DEPTH) + 1);
  localparam logic [CNT_W-1:0] START_LOAD = CNT_W'(START_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(KEY_LATENCY - 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(PIPE_DEPTH - 1);

  seq_state_t               state, state_nx;
  logic                     transfer;
  logic                     cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0]         cnt_load_val;
  logic [AES_KEY_WIDTH-1:0] round_key_q;
  logic                     start_q, ready_q;
  logic [EPOCH_WIDTH-1:0]   epoch_q;

  // The drain length is fixed at PIPE_DEPTH regardless of how many blocks
  // are actually in flight, so the issue strobe carries no information here.
  logic unused_data_valid;
  assign unused_data_valid = dataValidIn;

  assign keyAccept = (state == ST_IDLE) || (state == ST_RUN);
  assign dataStall = (state != ST_RUN);
  assign transfer  = keyValid && keyAccept;

  aes_cycle_counter #(.W(CNT_W)) u_cnt (
    .clock    (clock),
    .resetN   (resetN),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_nx     = state;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = '0;
    case (state)
      ST_IDLE: if (transfer) begin
        state_nx     = ST_START;
        cnt_load     = 1'b1;
        cnt_load_val = START_LOAD;
      end
      ST_RUN: if (transfer) begin
        state_nx     = ST_DRAIN;
        cnt_load     = 1'b1;
        cnt_load_val = DRAIN_LOAD;
      end
      ST_DRAIN: if (cnt_zero) begin
        state_nx     = ST_START;
        cnt_load     = 1'b1;
        cnt_load_val = START_LOAD;
      end else cnt_dec = 1'b1;
      ST_START: if (cnt_zero) begin
        state_nx     = ST_WAIT;
        cnt_load     = 1'b1;
        cnt_load_val = WAIT_LOAD;
      end else cnt_dec = 1'b1;
      ST_WAIT: if (cnt_zero) state_nx = ST_RUN;
               else          cnt_dec  = 1'b1;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state       <= ST_IDLE;
      round_key_q <= '0;
      start_q     <= 1'b0;
      ready_q     <= 1'b0;
      epoch_q     <= '0;
    end else begin
      state   <= state_nx;
      // Registered pulse: high exactly while the FSM sits in START.
      start_q <= (state_nx == ST_START);
      if (transfer) begin
        round_key_q <= keyIn;
        ready_q     <= 1'b0;
      end else if (state == ST_WAIT && cnt_zero) begin
        ready_q <= 1'b1;
        epoch_q <= epoch_q + 1'b1;
      end
    end
  end

  assign roundKeyInput   = round_key_q;
  assign startTransition = start_q;
  assign keysReady       = ready_q;
  assign keyEpoch        = epoch_q;

endmodule

// File: tb/tb_aes_key_sequencer.sv
module tb_aes_key_sequencer;

  logic         clock = 1'b0;
  logic         resetN = 1'b0;
  logic [127:0] keyIn = '0;
  logic         keyValid = 1'b0;
  logic         keyAccept;
  logic [127:0] roundKeyInput;
  logic         startTransition;
  logic         dataValidIn = 1'b0;
  logic         dataStall;
  logic         keysReady;
  logic [3:0]   keyEpoch;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] K1 = 128'h754620676e754b20796d207374616854;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K3 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K4 = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] K5 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

  aes_key_sequencer dut (
    .clock           (clock),
    .resetN          (resetN),
    .keyIn           (keyIn),
    .keyValid        (keyValid),
    .keyAccept       (keyAccept),
    .roundKeyInput   (roundKeyInput),
    .startTransition (startTransition),
    .dataValidIn     (dataValidIn),
    .dataStall       (dataStall),
    .keysReady       (keysReady),
    .keyEpoch        (keyEpoch)
  );

  always #10 clock = ~clock;

  // Advance past one rising edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    #5;
    checks++;
    if (keyAccept !== 1'b1 || dataStall !== 1'b1 || startTransition !== 1'b0 ||
        keysReady !== 1'b0 || keyEpoch !== 4'd0 || roundKeyInput !== 128'd0) begin
      errors++;
      $display("FAIL reset: acc=%b stall=%b st=%b rdy=%b ep=%0d rki=%h (want 1 1 0 0 0 0)",
               keyAccept, dataStall, startTransition, keysReady, keyEpoch, roundKeyInput);
    end
    tick();
    resetN = 1'b1;
    tick();
    checks++;
    if (keyAccept !== 1'b1 || dataStall !== 1'b1 || startTransition !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: acc=%b stall=%b st=%b", keyAccept, dataStall, startTransition);
    end
  endtask

  task automatic test_first_load();
    keyIn = K1; keyValid = 1'b1;
    tick();  // edge 0
    keyValid = 1'b0;
    checks++;
    if (roundKeyInput !== K1 || keysReady !== 1'b0 || keyAccept !== 1'b0) begin
      errors++;
      $display("FAIL first_load_edge0: rki=%h rdy=%b acc=%b want key %h, 0, 0",
               roundKeyInput, keysReady, keyAccept, K1);
    end
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) tick();
      checks++;
      if (startTransition !== (k <= 4)) begin
        errors++;
        $display("FAIL first_load_start edge %0d: st=%b want %b", k, startTransition, (k <= 4));
      end
      checks++;
      if (keysReady !== (k == 16) || dataStall !== (k != 16)) begin
        errors++;
        $display("FAIL first_load_ready edge %0d: rdy=%b stall=%b", k, keysReady, dataStall);
      end
    end
    checks++;
    if (keyEpoch !== 4'd1 || keyAccept !== 1'b1) begin
      errors++;
      $display("FAIL first_load_epoch: ep=%0d acc=%b want 1 1", keyEpoch, keyAccept);
    end
  endtask

  // Follow a rekey from RUN after its accepting edge up to edge 27.
  task automatic run_rekey(input logic [3:0] exp_epoch, input logic [127:0] exp_key,
                           input bit toggle, input bit hold_other);
    for (int k = 1; k <= 27; k++) begin
      if (toggle) dataValidIn = ~dataValidIn;
      tick();
      checks++;
      if (startTransition !== (k >= 11 && k <= 15)) begin
        errors++;
        $display("FAIL rekey_start edge %0d: st=%b want %b", k, startTransition, (k >= 11 && k <= 15));
      end
      checks++;
      if (keysReady !== (k == 27) || dataStall !== (k != 27) || keyAccept !== (k == 27) ||
          roundKeyInput !== exp_key) begin
        errors++;
        $display("FAIL rekey_state edge %0d: rdy=%b stall=%b acc=%b rki=%h hold=%0d",
                 k, keysReady, dataStall, keyAccept, roundKeyInput, hold_other);
      end
    end
    dataValidIn = 1'b0;
    checks++;
    if (keyEpoch !== exp_epoch) begin
      errors++;
      $display("FAIL rekey_epoch: ep=%0d want %0d", keyEpoch, exp_epoch);
    end
  endtask

  task automatic test_rekey();
    keyIn = K2; keyValid = 1'b1; dataValidIn = 1'b1;
    tick();  // edge 0
    keyValid = 1'b0;
    checks++;
    if (dataStall !== 1'b1 || keysReady !== 1'b0 || roundKeyInput !== K2 || startTransition !== 1'b0) begin
      errors++;
      $display("FAIL rekey_edge0: stall=%b rdy=%b st=%b rki=%h", dataStall, keysReady, startTransition, roundKeyInput);
    end
    run_rekey(4'd2, K2, 1'b1, 1'b0);
  endtask

  task automatic test_held_key();
    keyIn = K3; keyValid = 1'b1;
    tick();  // edge 0: K3 accepted from RUN
    keyIn = K4;  // next key held valid throughout
    checks++;
    if (roundKeyInput !== K3 || dataStall !== 1'b1) begin
      errors++;
      $display("FAIL held_edge0: rki=%h stall=%b want %h 1", roundKeyInput, dataStall, K3);
    end
    run_rekey(4'd3, K3, 1'b0, 1'b1);
    tick();  // edge 28: K4 taken in the single RUN cycle
    keyValid = 1'b0;
    checks++;
    if (roundKeyInput !== K4 || dataStall !== 1'b1 || keysReady !== 1'b0 || keyAccept !== 1'b0) begin
      errors++;
      $display("FAIL held_accept: rki=%h stall=%b rdy=%b acc=%b", roundKeyInput, dataStall, keysReady, keyAccept);
    end
    run_rekey(4'd4, K4, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    keyIn = K5; keyValid = 1'b1;
    tick();  // edge 0
    keyValid = 1'b0;
    for (int k = 1; k <= 13; k++) tick();  // after edge 13: 3rd START cycle
    checks++;
    if (startTransition !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: st=%b want 1", startTransition);
    end
    #5 resetN = 1'b0;
    #1;
    checks++;
    if (startTransition !== 1'b0 || keyAccept !== 1'b1 || dataStall !== 1'b1 ||
        keyEpoch !== 4'd0 || keysReady !== 1'b0 || roundKeyInput !== 128'd0) begin
      errors++;
      $display("FAIL mid_reset: st=%b acc=%b stall=%b ep=%0d rdy=%b rki=%h",
               startTransition, keyAccept, dataStall, keyEpoch, keysReady, roundKeyInput);
    end
    #2 resetN = 1'b1;
    tick();
    checks++;
    if (startTransition !== 1'b0 || keyAccept !== 1'b1 || dataStall !== 1'b1) begin
      errors++;
      $display("FAIL mid_idle: st=%b acc=%b stall=%b", startTransition, keyAccept, dataStall);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_ep;
    bit done;
    for (int i = 0; i < 16; i++) begin
      keyIn = {4{32'hA5A50000 + 32'(i)}};
      keyValid = 1'b1;
      tick();
      keyValid = 1'b0;
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
        tick();
        if (keysReady === 1'b1) done = 1'b1;
      end
      exp_ep = 4'(i + 1);
      checks++;
      if (!done || keyEpoch !== exp_ep) begin
        errors++;
        $display("FAIL b2b load %0d: ready=%0d ep=%0d want ep %0d", i, done, keyEpoch, exp_ep);
      end
    end
    checks++;
    if (keyEpoch !== 4'd0 || keysReady !== 1'b1) begin
      errors++;
      $display("FAIL b2b_wrap: ep=%0d rdy=%b want 0 1", keyEpoch, keysReady);
    end
  endtask

  initial begin
    test_reset();
    test_first_load();
    test_rekey();
    test_held_key();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
